// File: rtl/serial_tx_queue.sv
// Transmit byte queue feeding the AVR serial transmit handshake, with optional
// echo of received bytes. One byte issued per guard-plus-busy interval.
module serial_tx_queue #(
  parameter int DEPTH   = 16,
  parameter bit ECHO_EN = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_en,
  output logic                       wr_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       new_rx_data,
  output logic [7:0]                 tx_data,
  output logic                       new_tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_block,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, GUARD} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state, state_nxt;
  logic          full, empty, echo_req, echo_wr, prod_wr, push, pop, drop;
  logic [7:0]    push_data;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  // Echo cannot be stalled, so it owns the write port whenever it fires.
  assign echo_req  = ECHO_EN && new_rx_data;
  assign wr_ready  = !full && !echo_req;
  assign echo_wr   = echo_req && !full;
  assign prod_wr   = wr_en && wr_ready;
  assign push      = echo_wr || prod_wr;
  assign push_data = echo_wr ? rx_data : wr_data;
  assign drop      = (wr_en && !wr_ready) || (echo_req && full);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty && !tx_busy && !tx_block) begin
        pop       = 1'b1;
        state_nxt = GUARD;
      end
      // tx_busy rises only one cycle after the strobe; skip sampling it here.
      GUARD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      new_tx_data <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_data;
  end
endmodule

// File: tb/tb_serial_tx_queue.sv
// Randomized and directed bench for serial_tx_queue against a queue-based
// reference model of the transmit queue and its issue pacing.
module tb_serial_tx_queue;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    wr_data = '0, rx_data = '0, tx_data;
  logic          wr_en = 1'b0, new_rx_data = 1'b0, tx_busy = 1'b0, tx_block = 1'b0, clr_ovf = 1'b0;
  logic          wr_ready, new_tx_data, overflow;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  serial_tx_queue #(.DEPTH(DEPTH), .ECHO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .tx_block(tx_block),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  int          n_chk = 0, n_fail = 0;
  byte unsigned q[$];
  byte unsigned got[$];
  logic [7:0]  m_tx = 8'h00;
  bit          m_stb = 1'b0, m_ovf = 1'b0;
  int          cyc = 0, last_iss = -10, busy_len = 0, busy_cnt = 0, first_stb = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational ready, advance the model, then check registers.
  task automatic tick();
    bit full, ready, pop;
    #1;
    full  = (q.size() == DEPTH);
    ready = !full && !new_rx_data;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, ready});
    if (rst) begin
      q.delete(); m_ovf = 0; m_tx = 8'h00; m_stb = 0; last_iss = -10; busy_cnt = 0;
    end else begin
      // Issue needs two cycles since the previous issue decision.
      pop   = (cyc - last_iss >= 2) && q.size() > 0 && !tx_busy && !tx_block;
      m_stb = pop;
      if (pop) begin m_tx = q.pop_front(); last_iss = cyc; end
      if (new_rx_data && !full) q.push_back(rx_data);
      if (wr_en && ready)       q.push_back(wr_data);
      if ((wr_en && !ready) || (new_rx_data && full)) m_ovf = 1;
      else if (clr_ovf)                               m_ovf = 0;
    end
    @(posedge clk); #1;
    cyc++;
    chk("level", 32'(level), 32'(q.size()));
    chk("new_tx_data", {31'b0, new_tx_data}, {31'b0, m_stb});
    chk("tx_data", {24'b0, tx_data}, {24'b0, m_tx});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (new_tx_data) begin
      got.push_back(tx_data);
      if (first_stb < 0) first_stb = cyc;
    end
    if (busy_len > 0) begin
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (m_stb) busy_cnt = busy_len;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b; tick(); wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet();
    wr_en = 0; new_rx_data = 0; tx_block = 0; clr_ovf = 0;
    if (busy_len == 0) tx_busy = 0;
  endtask

  task automatic drain();
    int k;
    quiet();
    k = 0;
    while ((q.size() > 0 || m_stb) && k < 1000) begin tick(); k++; end
    chk("drain_done", 32'(q.size()), 32'd0);
    idle(2);
  endtask

  task automatic reset_dut();
    quiet(); rst = 1; idle(2); rst = 0;
  endtask

  task automatic set_busy(input int n);
    busy_len = n; busy_cnt = 0; tx_busy = 0;
  endtask

  initial begin
    byte unsigned hello[5];
    int wc, v;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    @(posedge clk); #1;
    reset_dut();

    // Ordering and first-issue latency, AVR busy for 10 cycles per byte.
    set_busy(10); got.delete(); first_stb = -1; wc = cyc;
    foreach (hello[i]) wr(hello[i]);
    drain();
    chk("first_latency", 32'(first_stb - wc), 32'd2);
    chk("hello_len", 32'(got.size()), 32'd5);
    foreach (hello[i]) if (i < got.size()) chk("hello_byte", 32'(got[i]), 32'(hello[i]));

    // Reset mid-drain discards queued bytes.
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    idle(14);
    rst = 1; idle(2); rst = 0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    got.delete(); idle(30);
    chk("rst_no_strobe", 32'(got.size()), 32'd0);

    // Full queue and sticky overflow.
    reset_dut(); set_busy(0); tx_busy = 1;
    for (int i = 0; i < 17; i++) wr(8'hA0 + 8'(i));
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", {31'b0, wr_ready}, 32'd0);
    chk("full_ovf", {31'b0, overflow}, 32'd1);
    clr_ovf = 1; tick(); clr_ovf = 0;
    chk("clr_ovf", {31'b0, overflow}, 32'd0);
    got.delete(); tx_busy = 0; drain();
    chk("full_len", 32'(got.size()), 32'd16);
    foreach (got[i]) chk("full_byte", 32'(got[i]), 32'(8'hA0 + i));

    // Wrap-around: fill to 16 then empty, repeatedly.
    reset_dut(); set_busy(0); got.delete(); v = 0;
    foreach (hello[j]) begin
      if (j > 2) break;
      tx_busy = 1;
      for (int i = 0; i < ((j == 2) ? 8 : 16); i++) begin wr(8'(v)); v++; end
      tx_busy = 0; drain();
    end
    chk("wrap_len", 32'(got.size()), 32'd40);
    foreach (got[i]) chk("wrap_byte", 32'(got[i]), 32'(i));

    // Echo wins over a simultaneous producer write.
    reset_dut(); got.delete();
    new_rx_data = 1; rx_data = 8'h41; wr_en = 1; wr_data = 8'h42;
    tick();
    quiet();
    chk("echo_ovf", {31'b0, overflow}, 32'd1);
    drain();
    chk("echo_len", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("echo_byte", 32'(got[0]), 32'h41);

    // Flow control on tx_block.
    reset_dut(); got.delete(); tx_block = 1;
    for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i));
    idle(10);
    chk("blocked", 32'(got.size()), 32'd0);
    tx_block = 0; set_busy(3); tick();
    chk("unblock_strobe", 32'(got.size()), 32'd1);
    drain();
    chk("flow_len", 32'(got.size()), 32'd3);

    // Randomized traffic.
    reset_dut(); set_busy(0);
    for (int r = 0; r < 4; r++) begin
      set_busy(int'($urandom_range(1, 4)));
      for (int i = 0; i < 150; i++) begin
        wr_en       = ($urandom_range(0, 9) < 6);
        wr_data     = 8'($urandom);
        new_rx_data = ($urandom_range(0, 9) == 0);
        rx_data     = 8'($urandom);
        tx_block    = ($urandom_range(0, 4) == 0);
        clr_ovf     = ($urandom_range(0, 19) == 0);
        tick();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
